wishbone_burst_manager: RTL and testbench
=========================================

// Module: wishbone_burst_manager
// PURPOSE
//  CPU-side Wishbone B4 classic manager with multi-beat burst, byte-lane select and ACK timeout.
//  Sits between a team core and wishbone_arbitrator (one manager slot); single accesses are LEN_I=1.
//  Adds incrementing/fixed-address bursts, per-beat data handshake, DONE/ERR status and a bus watchdog.
// PARAMETERS
//  ADDR_W     32   address width
//  DATA_W     32   data width, multiple of 8; SEL width = DATA_W/8, address step = DATA_W/8
//  MAX_BURST  8    max beats per request; LEN_W = $clog2(MAX_BURST+1)
//  TIMEOUT    255  cycles STB_O may wait for ACK_I before abort; 0 disables watchdog
// PORTS
//  wb_clk_i   in   1         clock
//  wb_rst_i   in   1         reset, synchronous, active-high
//  WRITE_I    in   1         start write request (sampled only in IDLE)
//  READ_I     in   1         start read request (sampled only in IDLE)
//  ADR_I      in   ADDR_W    start byte address
//  CPU_DAT_I  in   DATA_W    write data (beat 0 at request, beat k+1 while BEAT_O high)
//  SEL_I      in   DATA_W/8  byte lanes, used for every beat
//  LEN_I      in   LEN_W     beat count; 0 -> 1, >MAX_BURST -> MAX_BURST
//  INCR_I     in   1         1: address += DATA_W/8 per beat; 0: fixed address (FIFO periph)
//  DAT_I      in   DATA_W    bus read data
//  ACK_I      in   1         bus acknowledge
//  ADR_O      out  ADDR_W    bus address
//  DAT_O      out  DATA_W    bus write data
//  SEL_O      out  DATA_W/8  bus byte select
//  WE_O       out  1         bus write enable
//  STB_O      out  1         bus strobe
//  CYC_O      out  1         bus cycle
//  CPU_DAT_O  out  DATA_W    read data of last acked beat, held until next beat
//  BUSY_O     out  1         request in progress
//  BEAT_O     out  1         1-cycle pulse per acked beat
//  DONE_O     out  1         1-cycle pulse, last beat acked
//  ERR_O      out  1         1-cycle pulse, watchdog abort
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0; reset mid-burst drops CYC/STB next edge, no DONE/ERR.
//  - All outputs registered. States: IDLE, REQ, GAP.
//  - IDLE: READ_I|WRITE_I at edge N -> REQ; ADR/DAT/SEL/WE latched; CYC,STB,BUSY=1 after N.
//    WRITE_I and READ_I both high -> write. Requests outside IDLE ignored.
//  - REQ: STB=1. ACK_I at edge M -> BEAT_O=1, STB=0, beat cnt+1; read: CPU_DAT_O<=DAT_I.
//    Last beat -> IDLE: CYC=0, BUSY=0, DONE_O=1 same edge. Else -> GAP, CYC stays 1.
//  - GAP (1 cycle, BEAT_O high): ADR advances if INCR_I (mod 2^ADDR_W, wraps silently);
//    write: DAT_O<=CPU_DAT_I at end of GAP; -> REQ with STB=1 next edge. Min 2 cycles/beat.
//  - ACK_I outside REQ ignored. WE/SEL/LEN/INCR fixed for the whole burst.
//  - Watchdog: counter clears on entering REQ, counts each REQ cycle without ACK_I;
//    reaching TIMEOUT -> IDLE, CYC=STB=BUSY=0, ERR_O=1, no DONE_O; acked beats stand.
//  - ACK_I on the same cycle the counter hits TIMEOUT: ACK wins, no error.
// TESTING
//  1 single write 0x33000000 <- 0x12345678 SEL=F, ACK 1 cycle later -> 1 BEAT, DONE, BUSY low;
//    read back -> CPU_DAT_O=0x12345678.
//  2 write burst LEN=4 INCR=1 @0x33000010, data 0x11..44 per BEAT -> ADR_O 0x10,14,18,1C,
//    CYC_O never drops, exactly 4 BEAT_O, 1 DONE_O; read burst returns 0x11,22,33,44 per BEAT.
//  3 SEL=0001 write 0xAAAAAAAA over 0x12345678 -> full read 0x123456AA.
//  4 LEN=3 INCR=0 @0x31000000 -> ADR_O constant all 3 beats; LEN=0 -> 1 beat; LEN=9 -> 8 beats.
//  5 TIMEOUT=8, no ACK -> ERR_O at 8th REQ cycle, CYC/STB low, no DONE; ACK on cycle 8 -> no ERR.
//  6 ADR_I=0xFFFFFFFC LEN=2 INCR=1 -> 2nd beat ADR_O=0x0; wb_rst_i mid-burst -> CYC/STB/BUSY 0 next edge.

Source files
------------

// File: rtl/wishbone_burst_manager.sv
// Wishbone B4 classic manager: single and burst accesses with byte lanes,
// per-beat CPU data handshake, DONE/ERR status pulses and an ACK watchdog.
module wishbone_burst_manager #(
    parameter  int ADDR_W    = 32,
    parameter  int DATA_W    = 32,
    parameter  int MAX_BURST = 8,
    parameter  int TIMEOUT   = 255,
    localparam int SEL_W     = DATA_W / 8,
    localparam int LEN_W     = $clog2(MAX_BURST + 1)
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              WRITE_I,
    input  logic              READ_I,
    input  logic [ADDR_W-1:0] ADR_I,
    input  logic [DATA_W-1:0] CPU_DAT_I,
    input  logic [SEL_W-1:0]  SEL_I,
    input  logic [LEN_W-1:0]  LEN_I,
    input  logic              INCR_I,
    input  logic [DATA_W-1:0] DAT_I,
    input  logic              ACK_I,
    output logic [ADDR_W-1:0] ADR_O,
    output logic [DATA_W-1:0] DAT_O,
    output logic [SEL_W-1:0]  SEL_O,
    output logic              WE_O,
    output logic              STB_O,
    output logic              CYC_O,
    output logic [DATA_W-1:0] CPU_DAT_O,
    output logic              BUSY_O,
    output logic              BEAT_O,
    output logic              DONE_O,
    output logic              ERR_O
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [ADDR_W-1:0] ADR_STEP = ADDR_W'(SEL_W);
    localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    state_t            state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_cnt;
    logic [LEN_W-1:0]  len_clamp;
    logic              incr_q;
    logic [WD_W-1:0]   wd_cnt;
    logic              last_beat;
    logic              wd_expired;

    always_comb begin
        len_clamp = LEN_I;
        if (LEN_I == '0)
            len_clamp = LEN_W'(1);
        else if (LEN_I > LEN_MAX)
            len_clamp = LEN_MAX;
    end

    assign last_beat  = (beat_cnt + LEN_W'(1)) == len_q;
    // Counter value TIMEOUT-1 at an edge means this is the TIMEOUT-th REQ cycle without ACK.
    assign wd_expired = (TIMEOUT != 0) && (wd_cnt == WD_LAST);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            len_q     <= '0;
            beat_cnt  <= '0;
            incr_q    <= 1'b0;
            wd_cnt    <= '0;
            ADR_O     <= '0;
            DAT_O     <= '0;
            SEL_O     <= '0;
            WE_O      <= 1'b0;
            STB_O     <= 1'b0;
            CYC_O     <= 1'b0;
            CPU_DAT_O <= '0;
            BUSY_O    <= 1'b0;
            BEAT_O    <= 1'b0;
            DONE_O    <= 1'b0;
            ERR_O     <= 1'b0;
        end else begin
            BEAT_O <= 1'b0;
            DONE_O <= 1'b0;
            ERR_O  <= 1'b0;
            case (state)
                IDLE: begin
                    if (WRITE_I || READ_I) begin
                        state    <= REQ;
                        ADR_O    <= ADR_I;
                        DAT_O    <= CPU_DAT_I;
                        SEL_O    <= SEL_I;
                        WE_O     <= WRITE_I;
                        len_q    <= len_clamp;
                        incr_q   <= INCR_I;
                        beat_cnt <= '0;
                        wd_cnt   <= '0;
                        CYC_O    <= 1'b1;
                        STB_O    <= 1'b1;
                        BUSY_O   <= 1'b1;
                    end
                end
                REQ: begin
                    if (ACK_I) begin
                        BEAT_O   <= 1'b1;
                        STB_O    <= 1'b0;
                        beat_cnt <= beat_cnt + LEN_W'(1);
                        if (!WE_O)
                            CPU_DAT_O <= DAT_I;
                        if (last_beat) begin
                            state  <= IDLE;
                            CYC_O  <= 1'b0;
                            BUSY_O <= 1'b0;
                            DONE_O <= 1'b1;
                        end else begin
                            state <= GAP;
                        end
                    end else if (wd_expired) begin
                        state  <= IDLE;
                        CYC_O  <= 1'b0;
                        STB_O  <= 1'b0;
                        BUSY_O <= 1'b0;
                        ERR_O  <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                GAP: begin
                    // CPU presents the next write beat while BEAT_O is high.
                    state  <= REQ;
                    STB_O  <= 1'b1;
                    wd_cnt <= '0;
                    if (incr_q)
                        ADR_O <= ADR_O + ADR_STEP;
                    if (WE_O)
                        DAT_O <= CPU_DAT_I;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_burst_manager.sv
// Bench for wishbone_burst_manager: per-cycle expectations built from a transaction
// timeline model plus a reference memory, driven with randomized bursts and ACK delays.
module tb_wishbone_burst_manager;

    localparam int T = 8;
    localparam int N = 16384;

    logic tb_CLK = 1'b0;
    always #5 tb_CLK = ~tb_CLK;

    logic        wb_rst_i = 1'b1;
    logic        WRITE_I = 1'b0, READ_I = 1'b0, INCR_I = 1'b0, ACK_I = 1'b0;
    logic [31:0] ADR_I = '0, CPU_DAT_I = '0, DAT_I = '0;
    logic [3:0]  SEL_I = '0, LEN_I = '0;
    logic [31:0] ADR_O, DAT_O, CPU_DAT_O;
    logic [3:0]  SEL_O;
    logic        WE_O, STB_O, CYC_O, BUSY_O, BEAT_O, DONE_O, ERR_O;

    wishbone_burst_manager #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(8), .TIMEOUT(T)) dut (
        .wb_clk_i(tb_CLK), .wb_rst_i(wb_rst_i), .WRITE_I(WRITE_I), .READ_I(READ_I),
        .ADR_I(ADR_I), .CPU_DAT_I(CPU_DAT_I), .SEL_I(SEL_I), .LEN_I(LEN_I), .INCR_I(INCR_I),
        .DAT_I(DAT_I), .ACK_I(ACK_I), .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O),
        .WE_O(WE_O), .STB_O(STB_O), .CYC_O(CYC_O), .CPU_DAT_O(CPU_DAT_O), .BUSY_O(BUSY_O),
        .BEAT_O(BEAT_O), .DONE_O(DONE_O), .ERR_O(ERR_O)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_n   = 0;
    always @(posedge tb_CLK) cyc_n <= cyc_n + 1;

    // stimulus plan per cycle
    logic        p_rst[N], p_req[N], p_wr[N], p_rd[N], p_incr[N], p_cdat_v[N], p_ack[N], p_busy[N];
    logic [31:0] p_adr[N], p_cdat[N];
    logic [3:0]  p_sel[N], p_len[N];
    // expected outputs per cycle
    logic        e_rst[N], e_cyc[N], e_stb[N], e_busy[N], e_beat[N], e_done[N], e_err[N];
    logic        e_we[N], e_rdchk[N];
    logic [31:0] e_adr[N], e_dat[N], e_rdat[N];
    logic [3:0]  e_sel[N];

    logic [31:0] ref_mem[logic [29:0]];
    logic [31:0] slv_mem[logic [29:0]];

    function automatic logic [31:0] mem_init(input logic [29:0] w);
        return ({2'b00, w} * 32'h9E3779B1) ^ 32'hA5C30F1E;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (sel[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : mem_init(a[31:2]);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // compare process and event monitor
    logic [31:0] hold = '0;
    logic        stb_q;
    int          nb = 0, nd = 0, ne = 0;
    logic [31:0] adr_q[$];
    logic [31:0] rd_q[$];

    always @(negedge tb_CLK) begin : cmp
        int c;
        c = cyc_n;
        if (c > 0 && c < N) begin
            if (e_rst[c]) begin
                hold = '0;
                chk("rst_ctrl", {WE_O, STB_O, CYC_O, BUSY_O, BEAT_O, DONE_O, ERR_O, SEL_O}, '0);
                chk("rst_adr_dat", {ADR_O, DAT_O}, '0);
                chk("rst_cpu_dat", CPU_DAT_O, '0);
            end else begin
                chk("ctrl", {CYC_O, STB_O, BUSY_O, BEAT_O, DONE_O, ERR_O},
                    {e_cyc[c], e_stb[c], e_busy[c], e_beat[c], e_done[c], e_err[c]});
                if (e_stb[c]) begin
                    chk("bus_adr", ADR_O, e_adr[c]);
                    chk("bus_sel_we", {SEL_O, WE_O}, {e_sel[c], e_we[c]});
                    if (e_we[c]) chk("bus_wdat", DAT_O, e_dat[c]);
                end
                if (e_rdchk[c]) hold = e_rdat[c];
                chk("cpu_rdat", CPU_DAT_O, hold);
            end
            if (STB_O === 1'b1 && stb_q !== 1'b1) adr_q.push_back(ADR_O);
            stb_q = STB_O;
            if (BEAT_O === 1'b1) begin
                nb++;
                if (WE_O === 1'b0) rd_q.push_back(CPU_DAT_O);
            end
            if (DONE_O === 1'b1) nd++;
            if (ERR_O === 1'b1) ne++;
        end
    end

    // stimulus applier and bus slave
    always @(negedge tb_CLK) begin : stim
        int          c;
        logic [29:0] w;
        logic [31:0] v;
        c = cyc_n;
        if (c < N) begin
            wb_rst_i = p_rst[c];
            if (p_req[c]) begin
                WRITE_I = p_wr[c]; READ_I = p_rd[c]; ADR_I = p_adr[c];
                SEL_I = p_sel[c]; LEN_I = p_len[c]; INCR_I = p_incr[c];
            end else begin
                ADR_I = $urandom; SEL_I = 4'($urandom); LEN_I = 4'($urandom); INCR_I = 1'($urandom);
                if (p_busy[c] && $urandom_range(0, 3) == 0) begin
                    WRITE_I = 1'($urandom); READ_I = 1'($urandom);
                end else begin
                    WRITE_I = 1'b0; READ_I = 1'b0;
                end
            end
            CPU_DAT_I = p_cdat_v[c] ? p_cdat[c] : $urandom;
            if (p_ack[c]) begin
                ACK_I = 1'b1;
                w = ADR_O[31:2];
                v = slv_mem.exists(w) ? slv_mem[w] : mem_init(w);
                DAT_I = v;
                if (WE_O) slv_mem[w] = merge(v, DAT_O, SEL_O);
            end else begin
                ACK_I = !e_stb[c] && ($urandom_range(0, 3) == 0);
                DAT_I = $urandom;
            end
        end
    end

    logic [31:0] g_wdat[8];
    int          g_dly[8];
    int          next_c = 6;

    task automatic plan(input logic wr, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [3:0] len_in, input logic incr,
                        output int endc, output int req_c);
        int n, c, s, a, d, hi;
        logic [31:0] ba;
        if (next_c < cyc_n + 2) next_c = cyc_n + 2;
        c = next_c;
        req_c = c;
        n = (len_in == 4'd0) ? 1 : (len_in > 4'd8) ? 8 : int'(len_in);
        p_req[c] = 1'b1; p_wr[c] = wr; p_rd[c] = wr ? 1'($urandom) : 1'b1;
        p_adr[c] = adr; p_sel[c] = sel; p_len[c] = len_in; p_incr[c] = incr;
        p_cdat_v[c] = 1'b1; p_cdat[c] = g_wdat[0];
        s = c + 1;
        endc = s;
        for (int k = 0; k < n; k++) begin
            ba = adr + (incr ? 32'(4 * k) : 32'd0);
            d  = g_dly[k];
            hi = (d >= T) ? s + T - 1 : s + d;
            for (int t = s; t <= hi; t++) begin
                e_stb[t] = 1'b1; e_adr[t] = ba; e_sel[t] = sel; e_we[t] = wr; e_dat[t] = g_wdat[k];
            end
            if (d >= T) begin
                e_err[s + T] = 1'b1;
                endc = s + T;
                break;
            end
            p_ack[hi] = 1'b1;
            a = hi + 1;
            e_beat[a] = 1'b1;
            if (wr) ref_mem[ba[31:2]] = merge(ref_read(ba), g_wdat[k], sel);
            else begin
                e_rdchk[a] = 1'b1;
                e_rdat[a] = ref_read(ba);
            end
            if (k == n - 1) begin
                e_done[a] = 1'b1;
                endc = a;
            end else begin
                p_cdat_v[a] = 1'b1;
                p_cdat[a] = g_wdat[k + 1];
                s = a + 1;
            end
        end
        for (int t = c + 1; t < endc; t++) begin
            e_cyc[t] = 1'b1; e_busy[t] = 1'b1; p_busy[t] = 1'b1;
        end
        next_c = endc + $urandom_range(0, 2);
    endtask

    task automatic wait_until(input int t);
        while (cyc_n < t) @(negedge tb_CLK);
    endtask

    task automatic run(input logic wr, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [3:0] len_in, input logic incr);
        int endc, rc;
        plan(wr, adr, sel, len_in, incr, endc, rc);
        wait_until(endc + 2);
    endtask

    task automatic set_dly(input int v);
        for (int i = 0; i < 8; i++) g_dly[i] = v;
    endtask

    initial begin : drv
        int b0, d0, e0, endc, rc, rr, last_end;
        logic [31:0] exp_rd[4];
        for (int i = 0; i < N; i++) begin
            p_rst[i] = 1'b0; p_req[i] = 1'b0; p_wr[i] = 1'b0; p_rd[i] = 1'b0; p_incr[i] = 1'b0;
            p_cdat_v[i] = 1'b0; p_ack[i] = 1'b0; p_busy[i] = 1'b0;
            p_adr[i] = '0; p_cdat[i] = '0; p_sel[i] = '0; p_len[i] = '0;
            e_rst[i] = 1'b0; e_cyc[i] = 1'b0; e_stb[i] = 1'b0; e_busy[i] = 1'b0; e_beat[i] = 1'b0;
            e_done[i] = 1'b0; e_err[i] = 1'b0; e_we[i] = 1'b0; e_rdchk[i] = 1'b0;
            e_adr[i] = '0; e_dat[i] = '0; e_rdat[i] = '0; e_sel[i] = '0;
        end
        for (int i = 0; i < 4; i++) p_rst[i] = 1'b1;
        for (int i = 1; i <= 4; i++) e_rst[i] = 1'b1;
        set_dly(0);
        for (int i = 0; i < 8; i++) g_wdat[i] = $urandom;

        // single write then read back
        g_wdat[0] = 32'h12345678; g_dly[0] = 1;
        b0 = nb; d0 = nd;
        run(1'b1, 32'h33000000, 4'hF, 4'd1, 1'b1);
        chk("t1_wr_beats", nb - b0, 1);
        chk("t1_wr_done", nd - d0, 1);
        chk("t1_busy_low", BUSY_O, 0);
        g_dly[0] = 0;
        run(1'b0, 32'h33000000, 4'hF, 4'd1, 1'b1);
        chk("t1_readback", CPU_DAT_O, 32'h12345678);

        // incrementing write burst then read burst
        g_wdat[0] = 32'h11; g_wdat[1] = 32'h22; g_wdat[2] = 32'h33; g_wdat[3] = 32'h44;
        g_dly[0] = 0; g_dly[1] = 2; g_dly[2] = 1; g_dly[3] = 0;
        adr_q.delete(); b0 = nb; d0 = nd;
        run(1'b1, 32'h33000010, 4'hF, 4'd4, 1'b1);
        chk("t2_beats", nb - b0, 4);
        chk("t2_done", nd - d0, 1);
        chk("t2_adr_cnt", adr_q.size(), 4);
        while (adr_q.size() < 4) adr_q.push_back('x);
        chk("t2_adr0", adr_q[0], 32'h33000010);
        chk("t2_adr1", adr_q[1], 32'h33000014);
        chk("t2_adr2", adr_q[2], 32'h33000018);
        chk("t2_adr3", adr_q[3], 32'h3300001C);
        rd_q.delete();
        exp_rd[0] = 32'h11; exp_rd[1] = 32'h22; exp_rd[2] = 32'h33; exp_rd[3] = 32'h44;
        run(1'b0, 32'h33000010, 4'hF, 4'd4, 1'b1);
        chk("t2_rd_cnt", rd_q.size(), 4);
        while (rd_q.size() < 4) rd_q.push_back('x);
        for (int i = 0; i < 4; i++) chk("t2_rd_data", rd_q[i], exp_rd[i]);

        // single byte lane
        set_dly(0);
        g_wdat[0] = 32'hAAAAAAAA;
        run(1'b1, 32'h33000000, 4'b0001, 4'd1, 1'b1);
        run(1'b0, 32'h33000000, 4'hF, 4'd1, 1'b1);
        chk("t3_byte_lane", CPU_DAT_O, 32'h123456AA);

        // fixed address and length clamping
        adr_q.delete(); b0 = nb;
        run(1'b1, 32'h31000000, 4'hF, 4'd3, 1'b0);
        chk("t4_fixed_cnt", adr_q.size(), 3);
        while (adr_q.size() < 3) adr_q.push_back('x);
        for (int i = 0; i < 3; i++) chk("t4_fixed_adr", adr_q[i], 32'h31000000);
        b0 = nb;
        run(1'b0, 32'h31000000, 4'hF, 4'd0, 1'b1);
        chk("t4_len0_beats", nb - b0, 1);
        b0 = nb;
        run(1'b0, 32'h33000000, 4'hF, 4'd9, 1'b1);
        chk("t4_len9_beats", nb - b0, 8);

        // watchdog abort and ACK racing the watchdog
        d0 = nd; e0 = ne;
        g_dly[0] = T;
        run(1'b0, 32'h33000000, 4'hF, 4'd1, 1'b1);
        chk("t5_err", ne - e0, 1);
        chk("t5_no_done", nd - d0, 0);
        chk("t5_cyc_low", {CYC_O, STB_O, BUSY_O}, 0);
        d0 = nd; e0 = ne;
        g_dly[0] = T - 1;
        run(1'b0, 32'h33000000, 4'hF, 4'd1, 1'b1);
        chk("t5_late_ack_err", ne - e0, 0);
        chk("t5_late_ack_done", nd - d0, 1);

        // address wrap, then reset in the middle of a burst
        set_dly(0);
        adr_q.delete();
        run(1'b1, 32'hFFFFFFFC, 4'hF, 4'd2, 1'b1);
        chk("t6_wrap_cnt", adr_q.size(), 2);
        while (adr_q.size() < 2) adr_q.push_back('x);
        chk("t6_wrap_adr0", adr_q[0], 32'hFFFFFFFC);
        chk("t6_wrap_adr1", adr_q[1], 32'h00000000);
        set_dly(2);
        b0 = nb; d0 = nd; e0 = ne;
        plan(1'b0, 32'h33000000, 4'hF, 4'd4, 1'b1, endc, rc);
        rr = rc + 5;
        p_rst[rr] = 1'b1;
        for (int t = rr + 1; t <= endc + 2; t++) begin
            e_cyc[t] = 1'b0; e_stb[t] = 1'b0; e_busy[t] = 1'b0; e_beat[t] = 1'b0;
            e_done[t] = 1'b0; e_err[t] = 1'b0; e_rdchk[t] = 1'b0;
            p_ack[t] = 1'b0; p_busy[t] = 1'b0; p_cdat_v[t] = 1'b0;
        end
        e_rst[rr + 1] = 1'b1;
        next_c = rr + 2;
        wait_until(rr + 4);
        chk("t6_rst_beats", nb - b0, 1);
        chk("t6_rst_no_done", nd - d0, 0);
        chk("t6_rst_no_err", ne - e0, 0);
        chk("t6_rst_idle", {CYC_O, STB_O, BUSY_O}, 0);

        // randomized traffic
        last_end = cyc_n;
        for (int i = 0; i < 200 && next_c < N - 300; i++) begin
            int r;
            logic [31:0] a;
            a = ($urandom_range(0, 3) != 0) ? 32'h33000000 : 32'hFFFFFFE0;
            a = a + 32'(4 * $urandom_range(0, 7));
            for (int k = 0; k < 8; k++) begin
                g_wdat[k] = $urandom;
                r = $urandom_range(0, 29);
                g_dly[k] = (r == 0) ? T : (r == 1) ? T - 1 : $urandom_range(0, 3);
            end
            plan(1'($urandom), a, 4'($urandom), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3) != 0, endc, rc);
            last_end = endc;
        end
        wait_until(last_end + 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : time_limit
        #(N * 10 + 2000);
        $display("FAIL time_limit: got cycle %0d expected completion before %0d", cyc_n, N);
        $fatal(1, "simulation time limit reached");
    end

endmodule
